// File: rtl/divider_ctrl.sv
// Run-time controller for the counter-based clock divider.
// Optional period counter output enabled by DIV_CTRL_PERIOD_CNT_EN.
module divider_ctrl #(
  parameter int              W       = 28,
  parameter logic [W-1:0]    DIV_RST = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         clkout,
  output logic         tick,
  output logic         busy,
  output logic [W-1:0] div_active
`ifdef DIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]  periods
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t         r_state;
  logic [W-1:0]   r_cnt;
  logic [W-1:0]   r_div;
  logic [W-1:0]   r_pend;
  logic           r_pend_v;
  logic           r_clkout;
  logic           r_tick;

  logic           w_busy;
  logic           w_hit;
  logic           w_acc;
  logic           w_stop_lo;
  logic           w_fall;

  assign w_busy    = (r_state != S_IDLE);
  assign w_hit     = (r_cnt == r_div);
  assign w_acc     = cfg_valid && !r_pend_v;
  // A stop while low ends at once; it also pre-empts a rising toggle.
  assign w_stop_lo = (r_state == S_RUN) && stop && !r_clkout;
  // Full-period boundary: the 1->0 toggle of clkout.
  assign w_fall    = w_busy && w_hit && r_clkout;

  assign cfg_ready  = !r_pend_v;
  assign clkout     = r_clkout;
  assign tick       = r_tick;
  assign busy       = w_busy;
  assign div_active = r_div;

  // Main FSM: state, phase counter, divided clock, ratio and pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_div    <= DIV_RST;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_clkout <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt    <= '0;
          r_clkout <= 1'b0;
          if (r_pend_v) begin
            r_div    <= r_pend;
            r_pend_v <= 1'b0;
          end else if (w_acc) begin
            r_div <= cfg_div;
          end
          if (start && !stop) begin
            r_state <= S_RUN;
          end
        end
        S_RUN, S_DRAIN: begin
          if (w_stop_lo) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_hit) begin
            r_cnt    <= '0;
            r_clkout <= ~r_clkout;
            r_tick   <= ~r_clkout;
            if (r_clkout) begin
              if (r_pend_v) begin
                r_div <= r_pend;
              end
              if ((r_state == S_DRAIN) || stop) begin
                r_state <= S_IDLE;
              end
            end
          end else begin
            r_cnt <= r_cnt + ONE;
            if ((r_state == S_RUN) && stop && r_clkout) begin
              r_state <= S_DRAIN;
            end
          end
          // The slot is only filled when empty; a value taken on a
          // boundary cycle waits for the following boundary.
          if (w_acc) begin
            r_pend   <= cfg_div;
            r_pend_v <= 1'b1;
          end else if (w_fall) begin
            r_pend_v <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] r_periods;

  assign periods = r_periods;

  // Count completed periods; cleared by a start from IDLE, wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_periods <= 16'd0;
    end else if ((r_state == S_IDLE) && start && !stop) begin
      r_periods <= 16'd0;
    end else if (w_fall) begin
      r_periods <= r_periods + 16'd1;
    end
  end
`endif

endmodule
